pwm_dac: RTL and testbench
==========================

# pwm_dac

Audio output stage of the gf-minus1 tone path. It consumes the 8-bit unsigned samples produced by the sine wave generator and drives a single-bit pulse-width-modulated pin for an external RC low-pass filter. It also produces the one-cycle `sample_req` strobe that paces the generator through the generator's `clk_en` input. Each new sample is fetched and latched exactly once per PWM period.

## Interface
- `WIDTH`, default 8: sample and duty width. The PWM period is 2^WIDTH counts.
- `PRESCALE`, default 1: number of clk cycles per count tick. Valid range is 1..65535.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable. While low, the block is held idle.
- `sample_in`  in  WIDTH  unsigned sample from the generator.
- `sample_req`  out  1  one-clk pulse requesting the next sample; connects to the generator's `clk_en`.
- `pwm_out`  out  1  registered modulated output.

## Operation
- A prescaler counts 0..PRESCALE-1. `tick` is asserted in the cycle where the prescaler is at PRESCALE-1. With PRESCALE=1, `tick` is always 1.
- The period counter `cnt` (WIDTH bits) advances by 1 on each `tick` and wraps from 2^WIDTH-1 to 0.
- Sample request: `sample_req` = `tick` and `cnt` == 2^WIDTH-2. The generator updates its output on that same edge, so `sample_in` is stable while `cnt` == 2^WIDTH-1.
- Sample latch: on `tick` with `cnt` == 2^WIDTH-1, `duty` <= `sample_in`. The new duty takes effect from `cnt` == 0. Changes to `sample_in` at any other time are ignored.
- PWM mode: `pwm_out` <= (`cnt` < `duty`), registered every clk.
  - `duty`=0 gives a constant 0.
  - `duty`=2^WIDTH-1 gives a low level for exactly one count per period.
  - A 100% duty cycle is not reachable.
- `en` low:
  - prescaler, `cnt` and `sample_req` are forced to 0;
  - `pwm_out` goes to 0 on the next edge;
  - `duty` is retained.
  - When `en` rises, counting resumes from `cnt`=0.
- Reset, including reset asserted mid-period, clears on the next edge: prescaler=0, `cnt`=0, `duty`=0, accumulator=0, `sample_req`=0, `pwm_out`=0. Reset takes priority over `en`.

## Timing
- Output latency: one clk from `cnt`/`duty` to `pwm_out`.
- Sample-to-output latency: the sample requested in period N drives `pwm_out` throughout period N+1.
- `sample_req` period: 2^WIDTH × PRESCALE clks. The pulse is exactly one clk wide for every PRESCALE value.
- Simultaneous events: `sample_req` and the duty latch never fall in the same cycle, because they occur at different `cnt` values.
- First period after reset release with `en`=1: `cnt`=0 in the first cycle, and the first `sample_req` occurs in clk (2^WIDTH-1)×PRESCALE.

## Configuration
- `PWM_DAC_SD_EN` defined: the PWM comparator is replaced by a first-order sigma-delta modulator.
  - Registers: WIDTH-bit accumulator `acc`.
  - On every `tick`: {carry, `acc`} <= `acc` + `duty`, and `pwm_out` <= carry.
  - When `en` is low, `acc` is cleared to 0.
  - The counter, `sample_req` timing and duty latch are unchanged.
- `PWM_DAC_SD_EN` undefined: plain PWM as described under Operation, and no accumulator is instantiated.

## Structure
- Shared package `gf_dac_pkg`:
  - `DAC_WIDTH` = 8;
  - `DAC_CNT_MAX` = 2^DAC_WIDTH-1;
  - `DAC_REQ_CNT` = DAC_CNT_MAX-1.
  - The sine generator integration uses the same width constant.
- One sub-module, `tick_div`: the PRESCALE prescaler. It has clk, reset and en inputs and a one-cycle `tick` output, and is reusable for other paced stages.
- Period counter, latch and modulator stay in `pwm_dac`.

## Test plan
- Reset with outputs 0, then release with `en`=1 and PRESCALE=1 → `sample_req` goes high only in clk 255 after release, one cycle wide, and repeats every 256 clks. `pwm_out`=0 throughout the first period.
- `sample_in`=8'h40 held → from the second period on, `pwm_out` is high for exactly 64 consecutive clks starting one clk after `cnt`=0, then low for 192.
- `sample_in`=8'h00 → `pwm_out` is constantly 0. `sample_in`=8'hFF → `pwm_out` is low for exactly 1 clk per 256.
- `sample_in` toggled 8'h10→8'hC0 at `cnt`=100 → the current period still shows a 16-clk high pulse, and the next period shows a 192-clk high pulse.
- PRESCALE=4 → `sample_req` pulses are 1 clk wide with a spacing of 1024 clks. Asserting reset at `cnt`=77 gives `pwm_out`=0 and `sample_req`=0 on the next edge, and counting restarts from 0.
- With `PWM_DAC_SD_EN` defined and `sample_in`=8'h80 → after the latch, `pwm_out` alternates 0,1,0,1 on each tick. With `sample_in`=8'h40 → one 1 in every 4 ticks.

Source files
------------

// File: rtl/gf_dac_pkg.sv
// Shared constants for the gf-minus1 tone path (sine generator and pwm_dac).
package gf_dac_pkg;

  localparam int DAC_WIDTH   = 8;
  localparam int DAC_CNT_MAX = 2**DAC_WIDTH - 1;
  localparam int DAC_REQ_CNT = DAC_CNT_MAX - 1;

  // Prescaler counter width needed to hold 0..prescale-1.
  function automatic int presc_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Clock-enable divider: one-cycle tick every PRESCALE clk cycles while en is high.
module tick_div
  import gf_dac_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  always_comb begin
    tick  = en && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (!en || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM audio output with once-per-period sample fetch; PWM_DAC_SD_EN selects a
// first-order sigma-delta modulator instead of the PWM comparator.
module pwm_dac
  import gf_dac_pkg::*;
#(
  parameter int          WIDTH    = DAC_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  output logic             sample_req,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] REQ_CNT = CNT_MAX - 1'b1;

  logic             tick;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  tick_div #(
    .PRESCALE(PRESCALE)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  // The generator advances on sample_req, so sample_in is stable by the time
  // the counter reaches its last value, which is when duty is latched.
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (tick && (cnt_q == CNT_MAX)) begin
      duty_d = sample_in;
    end
  end

  assign sample_req = tick && (cnt_q == REQ_CNT);

`ifdef PWM_DAC_SD_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   acc_sum;

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, duty_q};
    acc_d   = acc_q;
    pwm_d   = pwm_q;
    if (!en) begin
      acc_d = '0;
      pwm_d = 1'b0;
    end else if (tick) begin
      acc_d = acc_sum[WIDTH-1:0];
      pwm_d = acc_sum[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    pwm_d = en && (cnt_q < duty_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac (PRESCALE=1 and PRESCALE=4 instances).
module tb_pwm_dac;
  import gf_dac_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, en, sample_req, pwm_out;
  logic [DAC_WIDTH-1:0] sample_in;
  logic                 reset4, en4, sample_req4, pwm_out4;
  logic [DAC_WIDTH-1:0] sample_in4;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int rq4_q[$];

  pwm_dac #(.WIDTH(DAC_WIDTH), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .en(en), .sample_in(sample_in),
    .sample_req(sample_req), .pwm_out(pwm_out)
  );

  pwm_dac #(.WIDTH(DAC_WIDTH), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset4), .en(en4), .sample_in(sample_in4),
    .sample_req(sample_req4), .pwm_out(pwm_out4)
  );

  // Called at the negedge of the cycle with cnt=0; returns at cnt=0 of the next period.
  // bits[j] is pwm_out one clk after count j; early/late drive sample_in before/after count 100.
  task automatic measure_period(input logic [7:0] early, input logic [7:0] late,
                                output logic [255:0] bits, output int rq_cnt, output int rq_pos);
    rq_cnt = 0;
    rq_pos = -1;
    bits   = '0;
    for (int j = 0; j < 256; j++) begin
      if (sample_req === 1'b1) begin
        rq_cnt++;
        rq_pos = j;
      end
      sample_in = (j < 100) ? early : late;
      @(negedge clk);
      bits[j] = pwm_out;
    end
  endtask

  task automatic test_reset();
    int req_seen;
    int pwm_seen;
    reset = 1'b1; en = 1'b1; sample_in = 8'hAA;
    reset4 = 1'b1; en4 = 1'b1; sample_in4 = 8'hC8;
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0) begin
      failures++; $display("FAIL reset_pwm: got %b expected 0", pwm_out);
    end
    checks++;
    if (sample_req !== 1'b0) begin
      failures++; $display("FAIL reset_req: got %b expected 0", sample_req);
    end
    checks++;
    if ({pwm_out4, sample_req4} !== 2'b00) begin
      failures++; $display("FAIL reset4_outs: got %b expected 00", {pwm_out4, sample_req4});
    end
    req_seen = 0;
    pwm_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sample_req !== 1'b0) req_seen++;
      if (pwm_out !== 1'b0) pwm_seen++;
    end
    checks++;
    if (req_seen != 0 || pwm_seen != 0) begin
      failures++;
      $display("FAIL reset_over_en: got req=%0d pwm=%0d active cycles expected 0 0", req_seen, pwm_seen);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

`ifndef PWM_DAC_SD_EN
  task automatic test_pwm_patterns();
    logic [7:0]   early [7] = '{8'h40, 8'h00, 8'hFF, 8'h10, 8'h10, 8'h55, 8'h30};
    logic [7:0]   late  [7] = '{8'h40, 8'h00, 8'hFF, 8'h10, 8'hC0, 8'h40, 8'h30};
    logic [255:0] bits;
    int rq_cnt, rq_pos, d, hi, first, last, exp_first, exp_last;
    exp_q.delete();
    exp_q.push_back(0);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(int'(late[k]));
      measure_period(early[k], late[k], bits, rq_cnt, rq_pos);
      d = exp_q.pop_front();
      hi = $countones(bits);
      first = -1; last = -1;
      for (int j = 0; j < 256; j++) begin
        if (bits[j]) begin
          if (first < 0) first = j;
          last = j;
        end
      end
      exp_first = (d > 0) ? 0 : -1;
      exp_last  = (d > 0) ? d - 1 : -1;
      checks++;
      if (rq_cnt != 1 || rq_pos != DAC_REQ_CNT) begin
        failures++;
        $display("FAIL sample_req_p%0d: got %0d pulses at %0d expected 1 at %0d", k, rq_cnt, rq_pos, DAC_REQ_CNT);
      end
      checks++;
      if (hi != d) begin
        failures++; $display("FAIL pwm_high_p%0d: got %0d high clks expected %0d", k, hi, d);
      end
      checks++;
      if (first != exp_first || last != exp_last) begin
        failures++;
        $display("FAIL pwm_shape_p%0d: got high %0d..%0d expected %0d..%0d", k, first, last, exp_first, exp_last);
      end
      $display("period %0d duty=%0d high=%0d req_pos=%0d", k, d, hi, rq_pos);
    end
  endtask

  task automatic test_enable();
    logic [255:0] bits;
    int rq_cnt, rq_pos, d, req_seen, pwm_seen;
    d = exp_q.pop_front();
    repeat (10) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1) begin
      failures++; $display("FAIL pwm_before_en_low: got %b expected 1", pwm_out);
    end
    en = 1'b0;
    sample_in = 8'hEE;
    @(negedge clk);
    checks++;
    if ({pwm_out, sample_req} !== 2'b00) begin
      failures++; $display("FAIL en_low_outs: got %b expected 00", {pwm_out, sample_req});
    end
    req_seen = 0; pwm_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sample_req !== 1'b0) req_seen++;
      if (pwm_out !== 1'b0) pwm_seen++;
    end
    checks++;
    if (req_seen != 0 || pwm_seen != 0) begin
      failures++;
      $display("FAIL en_low_idle: got req=%0d pwm=%0d active cycles expected 0 0", req_seen, pwm_seen);
    end
    en = 1'b1;
    measure_period(8'h77, 8'h77, bits, rq_cnt, rq_pos);
    checks++;
    if (rq_cnt != 1 || rq_pos != DAC_REQ_CNT) begin
      failures++;
      $display("FAIL en_resume_req: got %0d pulses at %0d expected 1 at %0d", rq_cnt, rq_pos, DAC_REQ_CNT);
    end
    checks++;
    if ($countones(bits) != d || bits[0] !== 1'b1) begin
      failures++;
      $display("FAIL en_duty_retained: got %0d high clks first=%b expected %0d first=1", $countones(bits), bits[0], d);
    end
    $display("enable resume duty=%0d high=%0d", d, $countones(bits));
  endtask
`else
  task automatic test_sigma_delta();
    logic [7:0]   samp [3] = '{8'h80, 8'h40, 8'h40};
    logic [255:0] bits;
    int rq_cnt, rq_pos, d, toggles, gap4;
    exp_q.delete();
    exp_q.push_back(0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(int'(samp[k]));
      measure_period(samp[k], samp[k], bits, rq_cnt, rq_pos);
      d = exp_q.pop_front();
      toggles = 0; gap4 = 0;
      for (int j = 1; j < 256; j++) if (bits[j] != bits[j-1]) toggles++;
      for (int j = 4; j < 256; j++) if (bits[j] && bits[j-4]) gap4++;
      checks++;
      if ($countones(bits) != d) begin
        failures++; $display("FAIL sd_ones_p%0d: got %0d expected %0d", k, $countones(bits), d);
      end
      checks++;
      if (rq_cnt != 1 || rq_pos != DAC_REQ_CNT) begin
        failures++; $display("FAIL sd_req_p%0d: got %0d at %0d expected 1 at %0d", k, rq_cnt, rq_pos, DAC_REQ_CNT);
      end
      if (d == 128) begin
        checks++;
        if (toggles != 255) begin
          failures++; $display("FAIL sd_alternate: got %0d toggles expected 255", toggles);
        end
      end else if (d == 64) begin
        checks++;
        if (gap4 != 63) begin
          failures++; $display("FAIL sd_every4: got %0d spaced pairs expected 63", gap4);
        end
      end
      $display("sd period %0d duty=%0d ones=%0d", k, d, $countones(bits));
    end
  endtask
`endif

  task automatic test_prescale4();
    int  pulses, exp_t, pwm_hi;
    logic prev;
    rq4_q.delete();
    rq4_q.push_back(1019);
    rq4_q.push_back(2043);
    reset4 = 1'b0; en4 = 1'b1; sample_in4 = 8'hC8;
    prev = 1'b0; pulses = 0;
    for (int t = 0; t <= 2356; t++) begin
      if (t > 0) @(negedge clk);
      if (sample_req4 === 1'b1) begin
        pulses++;
        checks++;
        if (prev) begin
          failures++; $display("FAIL req4_width: got high again at clk %0d expected 1-clk pulse", t);
        end else if (rq4_q.size() == 0) begin
          failures++; $display("FAIL req4_time: got pulse at clk %0d expected none", t);
        end else begin
          exp_t = rq4_q.pop_front();
          if (t != exp_t) begin
            failures++; $display("FAIL req4_time: got pulse at clk %0d expected %0d", t, exp_t);
          end
          $display("prescale4 sample_req at clk %0d", t);
        end
      end
      prev = sample_req4;
    end
    checks++;
    if (pulses != 2 || rq4_q.size() != 0) begin
      failures++; $display("FAIL req4_count: got %0d pulses expected 2", pulses);
    end
`ifndef PWM_DAC_SD_EN
    checks++;
    if (pwm_out4 !== 1'b1) begin
      failures++; $display("FAIL pwm4_cnt77: got %b expected 1", pwm_out4);
    end
`endif
    reset4 = 1'b1;
    @(negedge clk);
    checks++;
    if ({pwm_out4, sample_req4} !== 2'b00) begin
      failures++; $display("FAIL reset4_mid: got %b expected 00", {pwm_out4, sample_req4});
    end
    reset4 = 1'b0;
    rq4_q.push_back(1019);
    prev = 1'b0; pulses = 0; pwm_hi = 0;
    for (int t = 0; t <= 1100; t++) begin
      if (t > 0) @(negedge clk);
      if (t >= 1 && t <= 1023 && pwm_out4 !== 1'b0) pwm_hi++;
      if (sample_req4 === 1'b1) begin
        pulses++;
        checks++;
        if (prev || rq4_q.size() == 0) begin
          failures++; $display("FAIL req4_restart: got extra pulse at clk %0d expected none", t);
        end else begin
          exp_t = rq4_q.pop_front();
          if (t != exp_t) begin
            failures++; $display("FAIL req4_restart: got pulse at clk %0d expected %0d", t, exp_t);
          end
          $display("prescale4 restart sample_req at clk %0d", t);
        end
      end
      prev = sample_req4;
    end
    checks++;
    if (pulses != 1 || rq4_q.size() != 0) begin
      failures++; $display("FAIL req4_restart_count: got %0d pulses expected 1", pulses);
    end
    checks++;
    if (pwm_hi != 0) begin
      failures++; $display("FAIL pwm4_after_reset: got %0d high clks expected 0", pwm_hi);
    end
  endtask

  initial begin
    test_reset();
`ifndef PWM_DAC_SD_EN
    test_pwm_patterns();
    test_enable();
`else
    test_sigma_delta();
`endif
    test_prescale4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
